// File: rtl/sr_chk_pkg.sv
// sr_chk_pkg: shared types and constants for the PRBS-7 integrity checker.
// State encoding is visible on the checker's state port.
package sr_chk_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    // x^7 + x^6 + 1: expected bit = lfsr[6] ^ lfsr[5]
    localparam int TAP_HI = 6;
    localparam int TAP_LO = 5;

    localparam int PRBS_LEN_D    = 7;
    localparam int LOCK_MATCH_D  = 16;
    localparam int LOSS_ERRS_D   = 8;
    localparam int LOSS_WINDOW_D = 64;
    localparam int CNT_W_D       = 16;

endpackage

// File: rtl/sr_prbs_lfsr.sv
// sr_prbs_lfsr: PRBS-7 reference register for the checker.
// Loads received bits while syncing, free-runs on its own feedback once locked.
module sr_prbs_lfsr
    import sr_chk_pkg::*;
#(
    parameter int LEN = PRBS_LEN_D
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic load_sel,
    input  logic bit_in,
    output logic expected,
    output logic all_zero
);

    logic [LEN-1:0] lfsr_q;
    logic           shift_in;

    assign expected = lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO];
    assign all_zero = (lfsr_q == '0);
    assign shift_in = load_sel ? bit_in : expected;

    // Shift register advances once per accepted sample
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
        end else if (shift_en) begin
            lfsr_q <= {lfsr_q[LEN-2:0], shift_in};
        end
    end

endmodule

// File: rtl/sr_prbs_checker.sv
// sr_prbs_checker: self-synchronising PRBS-7 checker on the shift-register output.
// Hunts, verifies, then counts errors and bits while locked.
module sr_prbs_checker
    import sr_chk_pkg::*;
#(
    parameter int PRBS_LEN    = PRBS_LEN_D,
    parameter int LOCK_MATCH  = LOCK_MATCH_D,
    parameter int LOSS_ERRS   = LOSS_ERRS_D,
    parameter int LOSS_WINDOW = LOSS_WINDOW_D,
    parameter int CNT_W       = CNT_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
    output logic [1:0]       state
);

    localparam int FILL_W  = $clog2(PRBS_LEN + 1);
    localparam int MATCH_W = $clog2(LOCK_MATCH + 1);
    localparam int WIN_W   = $clog2(LOSS_WINDOW);
    localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(PRBS_LEN - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCH - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOSS_WINDOW - 1);
    localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_ERRS - 1);

    chk_state_e         state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               pulse_q, pulse_d;
    logic               locked_q, locked_d;

    logic exp_bit;
    logic lfsr_zero;
    logic mismatch;
    logic err_sat;
    logic bit_sat;

    sr_prbs_lfsr #(
        .LEN(PRBS_LEN)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (bit_valid),
        .load_sel (state_q != LOCKED),
        .bit_in   (bit_in),
        .expected (exp_bit),
        .all_zero (lfsr_zero)
    );

    assign mismatch = (bit_in != exp_bit);
    assign err_sat  = (err_cnt_q == {CNT_W{1'b1}});
    assign bit_sat  = (bit_cnt_q == {CNT_W{1'b1}});

    // Next-state, counter and output logic for each accepted sample
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;
        pulse_d   = 1'b0;

        if (bit_valid) begin
            unique case (state_q)
                HUNT: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_LAST) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    if (!mismatch && !lfsr_zero) begin
                        match_d = match_q + 1'b1;
                        if (match_q == MATCH_LAST) begin
                            state_d   = LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end
                end
                LOCKED: begin
                    if (!bit_sat) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (mismatch) begin
                        pulse_d = 1'b1;
                        if (!err_sat) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    if (mismatch && win_err_q == WERR_LAST) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_err_q + WERR_W'(mismatch);
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = '0;
                end
            endcase
        end

        // A clear takes priority over this cycle's increment
        if (clr_cnt) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    assign locked_d = (state_d == LOCKED);

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            fill_q    <= '0;
            match_q   <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
            pulse_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            pulse_q   <= pulse_d;
            locked_q  <= locked_d;
        end
    end

    assign state     = state_q;
    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_count = err_cnt_q;
    assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_sr_prbs_checker.sv
// tb_sr_prbs_checker: randomized PRBS-7 stimulus against a history-queue model.
// Counter width is reduced so saturation is reachable in a short run.
module tb_sr_prbs_checker;

    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] bit_count;
    logic [1:0]    state;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sr_prbs_checker #(
        .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count),
        .state     (state)
    );

    // Reference model: reference history of the last 7 bits, newest at the back
    bit hist[$];
    bit gen[$];
    int m_state = 0;
    int m_fill  = 0;
    int m_match = 0;
    int m_wc    = 0;
    int m_we    = 0;
    int m_errc  = 0;
    int m_bitc  = 0;
    bit m_pulse = 0;

    task automatic check(string tag, int obs, int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_step(bit r, bit v, bit b, bit c);
        bit e;
        bit z;
        m_pulse = 0;
        if (r) begin
            m_state = 0; m_fill = 0; m_match = 0;
            m_wc = 0; m_we = 0; m_errc = 0; m_bitc = 0;
            hist.delete();
            repeat (7) hist.push_back(1'b0);
            return;
        end
        if (c) begin
            m_errc = 0;
            m_bitc = 0;
        end
        if (!v) return;
        e = hist[hist.size()-7] ^ hist[hist.size()-6];
        z = 1;
        foreach (hist[i]) if (hist[i]) z = 0;
        case (m_state)
            0: begin
                hist.push_back(b);
                m_fill++;
                if (m_fill == 7) begin
                    m_state = 1;
                    m_match = 0;
                end
            end
            1: begin
                hist.push_back(b);
                if (b == e && !z) begin
                    m_match++;
                    if (m_match == 16) begin
                        m_state = 2; m_wc = 0; m_we = 0;
                    end
                end else begin
                    m_state = 0;
                    m_fill = 0;
                end
            end
            default: begin
                hist.push_back(e);
                if (!c && m_bitc < SAT) m_bitc++;
                if (b != e) begin
                    m_pulse = 1;
                    m_we++;
                    if (!c && m_errc < SAT) m_errc++;
                end
                if (m_we == 8) begin
                    m_state = 0;
                    m_fill = 0;
                end else begin
                    m_wc++;
                    if (m_wc == 64) begin
                        m_wc = 0;
                        m_we = 0;
                    end
                end
            end
        endcase
        if (hist.size() > 7) void'(hist.pop_front());
    endtask

    task automatic step(bit r, bit v, bit b, bit c);
        @(negedge clk);
        rst = r; bit_valid = v; bit_in = b; clr_cnt = c;
        @(posedge clk);
        model_step(r, v, b, c);
        #1;
        check("state", int'(state), m_state);
        check("locked", int'(locked), int'(m_state == 2));
        check("err_pulse", int'(err_pulse), int'(m_pulse));
        check("err_count", int'(err_count), m_errc);
        check("bit_count", int'(bit_count), m_bitc);
    endtask

    task automatic send(bit b, bit c, int gap);
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 1'b1, b, c);
    endtask

    function automatic bit prbs_next();
        bit b;
        b = gen[gen.size()-7] ^ gen[gen.size()-6];
        gen.push_back(b);
        void'(gen.pop_front());
        return b;
    endfunction

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Clean stream from HUNT with fill=0: lock must appear on the 23rd bit
    task automatic relock(string tag, int gmax);
        for (int i = 1; i <= 23; i++) begin
            send(prbs_next(), 1'b0, $urandom_range(0, gmax));
            if (i == 22) check({tag, "_pre_lock"}, int'(locked), 0);
            if (i == 23) check({tag, "_lock_at_23"}, int'(locked), 1);
        end
    endtask

    initial begin
        int seed;
        bit b;
        bit saw_lock;
        bit saw_verify;
        int flips;

        seed = $urandom_range(1, 127);
        for (int k = 0; k < 7; k++) gen.push_back(1'((seed >> k) & 1));
        repeat (7) hist.push_back(1'b0);

        // 1: reset state, then clean stream every 2nd clk
        do_reset();
        check("rst_state", int'(state), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_errc", int'(err_count), 0);
        for (int i = 1; i <= 40; i++) begin
            send(prbs_next(), 1'b0, 1);
            if (i == 22) check("s1_pre_lock", int'(locked), 0);
            if (i == 23) check("s1_lock_at_23", int'(locked), 1);
        end
        check("s1_errc", int'(err_count), 0);
        check("s1_bitc", int'(bit_count), 17);

        // 2: three isolated flips while locked
        for (int i = 0; i < 40; i++) begin
            b = prbs_next();
            if (i == 5 || i == 17 || i == 29) b = ~b;
            send(b, 1'b0, $urandom_range(0, 2));
        end
        check("s2_errc", int'(err_count), 3);
        check("s2_locked", int'(locked), 1);

        // 3: eight flips inside one window force HUNT, then relock keeps count
        do_reset();
        relock("s3a", 2);
        for (int i = 0; i < 30; i++) begin
            b = prbs_next();
            if (i % 4 == 1) b = ~b;
            send(b, 1'b0, $urandom_range(0, 2));
            if (i == 25) check("s3_locked_at_7", int'(state), 2);
            if (i == 29) check("s3_hunt_at_8", int'(state), 0);
        end
        check("s3_errc", int'(err_count), 8);
        relock("s3b", 2);
        check("s3_errc_kept", int'(err_count), 8);

        // 4: constant streams never lock
        for (int v = 0; v < 2; v++) begin
            do_reset();
            saw_lock = 0;
            saw_verify = 0;
            for (int i = 0; i < 500; i++) begin
                send(1'(v), 1'b0, $urandom_range(0, 1));
                if (locked) saw_lock = 1;
                if (state == 2'd1) saw_verify = 1;
            end
            check(v == 0 ? "s4_zero_nolock" : "s4_one_nolock", int'(saw_lock), 0);
            check(v == 0 ? "s4_zero_verify" : "s4_one_verify", int'(saw_verify), 1);
        end

        // 5: clear on an error bit, then drive both counters to saturation
        do_reset();
        relock("s5", 1);
        b = prbs_next();
        send(~b, 1'b1, 0);
        check("s5_clr_errc", int'(err_count), 0);
        check("s5_clr_pulse", int'(err_pulse), 1);
        check("s5_clr_bitc", int'(bit_count), 0);
        for (int n = 1; n < 44 * 64; n++) begin
            b = prbs_next();
            if ((n % 64) % 10 == 5) b = ~b;
            send(b, 1'b0, 0);
        end
        check("s5_err_sat", int'(err_count), SAT);
        check("s5_bit_sat", int'(bit_count), SAT);
        check("s5_locked", int'(locked), 1);

        // 6: reset mid-VERIFY and mid-LOCKED
        do_reset();
        for (int i = 0; i < 12; i++) send(prbs_next(), 1'b0, 1);
        check("s6_in_verify", int'(state), 1);
        step(1'b1, 1'b1, prbs_next(), 1'b0);
        check("s6v_state", int'(state), 0);
        check("s6v_match_gone", int'(locked), 0);
        relock("s6a", 1);
        flips = 0;
        for (int i = 0; i < 10; i++) begin
            b = prbs_next();
            if (i == 3) b = ~b;
            send(b, 1'b0, 1);
        end
        check("s6_pre_rst_errc", int'(err_count), 1);
        step(1'b1, 1'b1, prbs_next(), 1'b1);
        check("s6l_state", int'(state), 0);
        check("s6l_locked", int'(locked), 0);
        check("s6l_errc", int'(err_count), 0);
        check("s6l_bitc", int'(bit_count), 0);
        check("s6l_pulse", int'(err_pulse), 0);
        relock("s6b", 2);

        // 7: random soak with sparse errors, clears and resets
        for (int i = 0; i < 1500; i++) begin
            b = prbs_next();
            if ($urandom_range(0, 19) == 0) begin
                b = ~b;
                flips++;
            end
            if ($urandom_range(0, 999) == 0) step(1'b1, 1'b0, 1'b0, 1'b0);
            send(b, 1'($urandom_range(0, 99) == 0), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
